// File: rtl/lcd_message_sequencer_if.sv
// Bus between the message sequencer, the character ROM and the lcd driver.
// master = sequencer side, slave = ROM/driver/host side.
interface lcd_message_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int PAGE_W = 2
);
  logic              load;
  logic [PAGE_W-1:0] page_sel;
  logic              lcd_busy;
  logic [ADDR_W-1:0] rom_address;
  logic [8:0]        rom_data;
  logic [8:0]        d_in;
  logic              data_ready;
  logic              seq_busy;
  logic              init_done;

  modport master (
    input  load, page_sel, lcd_busy, rom_data,
    output rom_address, d_in, data_ready, seq_busy, init_done
  );

  modport slave (
    output load, page_sel, lcd_busy, rom_data,
    input  rom_address, d_in, data_ready, seq_busy, init_done
  );
endinterface

// File: rtl/lcd_message_sequencer.sv
// LCD message sequencer: plays the ROM init sequence, then renders a
// selectable page of ROWS x COLS characters, inserting a set-DDRAM-address
// command before every row. Each word is handed to the lcd driver with a
// one-cycle data_ready strobe and completes after busy goes high then low.
module lcd_message_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int INIT_LEN = 4,
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int PAGE_W   = 2
) (
  input logic                    clock,
  input logic                    internal_reset_n,
  lcd_message_sequencer_if.master bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int AW2   = ADDR_W + 2;

  typedef enum logic [2:0] {
    FETCH, ISSUE, WAIT_HI, WAIT_LO, ADVANCE, IDLE
  } state_t;

  typedef enum logic [1:0] {
    INIT, ROWCMD, CHAR
  } step_t;

  state_t            state;
  step_t             step;
  logic [IDX_W-1:0]  index;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [PAGE_W-1:0] page;
  logic              pending_load;
  logic [AW2-1:0]    char_addr;

  // Set-DDRAM-address command for the start of a row (HD44780 row bases).
  function automatic logic [8:0] row_cmd(input logic [ROW_W-1:0] r);
    logic [7:0] base;
    case (2'(r))
      2'd0:    base = 8'h00;
      2'd1:    base = 8'h40;
      2'd2:    base = 8'h14;
      default: base = 8'h54;
    endcase
    return {1'b0, 8'h80 | base};
  endfunction

  // ROM address of the current character, computed with headroom then truncated.
  always_comb begin
    char_addr = AW2'(INIT_LEN)
              + AW2'(page) * AW2'(ROWS * COLS)
              + AW2'(row) * AW2'(COLS)
              + AW2'(col);
  end

  // Sequencer FSM with registered bus outputs.
  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      state           <= FETCH;
      step            <= INIT;
      index           <= '0;
      row             <= '0;
      col             <= '0;
      page            <= '0;
      pending_load    <= 1'b0;
      bus.rom_address <= '0;
      bus.d_in        <= '0;
      bus.data_ready  <= 1'b0;
      bus.seq_busy    <= 1'b1;
      bus.init_done   <= 1'b0;
    end else begin
      // A load while busy is remembered; the page register can take the new
      // value at once because the next ADVANCE always restarts rendering.
      if (bus.load && state != IDLE) begin
        pending_load <= 1'b1;
        page         <= bus.page_sel;
      end

      case (state)
        FETCH: begin
          if (step == INIT) begin
            bus.rom_address <= ADDR_W'(index);
          end else if (step == CHAR) begin
            bus.rom_address <= ADDR_W'(char_addr);
          end
          state <= ISSUE;
        end

        ISSUE: begin
          if (bus.lcd_busy) begin
            bus.data_ready <= 1'b0;
          end else begin
            bus.d_in       <= (step == ROWCMD) ? row_cmd(row) : bus.rom_data;
            bus.data_ready <= 1'b1;
            state          <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          bus.data_ready <= 1'b0;
          if (bus.lcd_busy) state <= WAIT_LO;
        end

        WAIT_LO: begin
          if (!bus.lcd_busy) state <= ADVANCE;
        end

        ADVANCE: begin
          state <= FETCH;
          if (step == INIT && index != IDX_W'(INIT_LEN - 1)) begin
            // Loads during init stay pending until the last init word.
            index <= index + 1'b1;
          end else if (bus.load || pending_load) begin
            if (step == INIT) bus.init_done <= 1'b1;
            pending_load <= 1'b0;
            step         <= ROWCMD;
            row          <= '0;
            col          <= '0;
          end else begin
            case (step)
              INIT: begin
                bus.init_done <= 1'b1;
                step          <= ROWCMD;
                row           <= '0;
                col           <= '0;
              end
              ROWCMD: begin
                step <= CHAR;
                col  <= '0;
              end
              default: begin
                if (col != COL_W'(COLS - 1)) begin
                  col <= col + 1'b1;
                end else if (row != ROW_W'(ROWS - 1)) begin
                  row  <= row + 1'b1;
                  col  <= '0;
                  step <= ROWCMD;
                end else begin
                  state        <= IDLE;
                  bus.seq_busy <= 1'b0;
                end
              end
            endcase
          end
        end

        IDLE: begin
          if (bus.load) begin
            page         <= bus.page_sel;
            step         <= ROWCMD;
            row          <= '0;
            col          <= '0;
            state        <= FETCH;
            bus.seq_busy <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
